// File: rtl/usb_tx_serializer.sv
// USB transmit serializer: shifts out sync/pid/crc/data fields with
// bit stuffing and NRZI, drives D+/D- with J idle and SE0 end-of-packet.
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sync_load_enable,
    input  logic        pid_load_enable,
    input  logic        crc5_load_enable,
    input  logic        crc16_load_enable,
    input  logic        data_load_enable,
    input  logic [7:0]  trans_sync,
    input  logic [7:0]  trans_pid,
    input  logic [4:0]  trans_crc5,
    input  logic [15:0] trans_crc16,
    input  logic [63:0] trans_data,
    input  logic        idle_transmitting,
    input  logic        sync_transmitting,
    input  logic        pid_transmitting,
    input  logic        crc5_transmitting,
    input  logic        crc16_transmitting,
    input  logic        data_transmitting,
    input  logic        eop_transmitting,
    output logic        sync_bits_transmitted,
    output logic        pid_bits_transmitted,
    output logic        crc5_bits_transmitted,
    output logic        crc16_bits_transmitted,
    output logic        data_bits_transmitted,
    output logic        d_plus,
    output logic        d_minus
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_DONE = TW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        F_SYNC  = 3'd0,
        F_PID   = 3'd1,
        F_CRC5  = 3'd2,
        F_CRC16 = 3'd3,
        F_DATA  = 3'd4
    } field_t;

    function automatic logic [4:0] rev5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    // Shifter always presents the next bit at [0]; MSB-first fields
    // are bit-reversed on load so one shift direction serves all.
    logic [63:0]   r_shift;
    logic [6:0]    r_left;
    field_t        r_field;
    logic          r_active;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_ones;
    logic          r_level;
    logic [4:0]    r_done;

    logic          w_load;
    logic [63:0]   w_ld_shift;
    logic [6:0]    w_ld_len;
    field_t        w_ld_field;

    logic [63:0]   w_src_shift;
    logic [6:0]    w_src_left;
    logic          w_wrap;
    logic          w_fin;
    logic          w_start;

    logic [63:0]   w_st_shift;
    logic [6:0]    w_st_left;
    logic          w_st_level;
    logic [2:0]    w_st_ones;

    logic [63:0]   w_n_shift;
    logic [6:0]    w_n_left;
    field_t        w_n_field;
    logic          w_n_active;
    logic [TW-1:0] w_n_timer;
    logic [2:0]    w_n_ones;
    logic          w_n_level;
    logic [4:0]    w_n_done;

    logic          w_unused;

    // Phase flags other than idle/eop carry no information the
    // serializer needs; timing runs from its own field state.
    assign w_unused = ^{sync_transmitting, pid_transmitting,
                        crc5_transmitting, crc16_transmitting,
                        data_transmitting};

    assign w_load = sync_load_enable | pid_load_enable |
                    crc5_load_enable | crc16_load_enable |
                    data_load_enable;

    // Select the field to capture; sync wins, data loses.
    always_comb begin
        w_ld_shift = '0;
        w_ld_len   = 7'd0;
        w_ld_field = F_SYNC;
        if (sync_load_enable) begin
            w_ld_shift = {56'd0, trans_sync};
            w_ld_len   = 7'd8;
            w_ld_field = F_SYNC;
        end else if (pid_load_enable) begin
            w_ld_shift = {56'd0, trans_pid};
            w_ld_len   = 7'd8;
            w_ld_field = F_PID;
        end else if (crc5_load_enable) begin
            w_ld_shift = {59'd0, rev5(trans_crc5)};
            w_ld_len   = 7'd5;
            w_ld_field = F_CRC5;
        end else if (crc16_load_enable) begin
            w_ld_shift = {48'd0, rev16(trans_crc16)};
            w_ld_len   = 7'd16;
            w_ld_field = F_CRC16;
        end else if (data_load_enable) begin
            w_ld_shift = trans_data;
            w_ld_len   = 7'd64;
            w_ld_field = F_DATA;
        end
    end

    // Work out what the next bit period carries: a stuffed 0 when six
    // ones are pending, otherwise the next field bit, NRZI-encoded.
    always_comb begin
        w_src_shift = w_load ? w_ld_shift : r_shift;
        w_src_left  = w_load ? w_ld_len : r_left;
        w_wrap      = r_active && (r_timer == T_LAST);
        w_fin       = (r_left == 7'd0) && (r_ones != 3'd6);
        w_start     = !eop_transmitting &&
                      (w_load || (w_wrap && !w_fin));
        w_st_shift  = w_src_shift;
        w_st_left   = w_src_left;
        w_st_level  = ~r_level;
        w_st_ones   = 3'd0;
        if (r_ones != 3'd6) begin
            w_st_shift = w_src_shift >> 1;
            w_st_left  = w_src_left - 7'd1;
            if (w_src_shift[0]) begin
                w_st_level = r_level;
                w_st_ones  = r_ones + 3'd1;
            end
        end
    end

    // Next-state selection; EOP overrides loads, timing and idle.
    always_comb begin
        w_n_shift  = r_shift;
        w_n_left   = r_left;
        w_n_field  = r_field;
        w_n_active = r_active;
        w_n_timer  = r_timer;
        w_n_ones   = r_ones;
        w_n_level  = r_level;
        w_n_done   = 5'd0;
        if (eop_transmitting) begin
            w_n_shift  = '0;
            w_n_left   = 7'd0;
            w_n_active = 1'b0;
            w_n_timer  = '0;
            w_n_ones   = 3'd0;
            w_n_level  = 1'b1;
        end else if (w_start) begin
            w_n_shift  = w_st_shift;
            w_n_left   = w_st_left;
            w_n_level  = w_st_level;
            w_n_ones   = w_st_ones;
            w_n_timer  = '0;
            w_n_active = 1'b1;
            if (w_load) w_n_field = w_ld_field;
        end else if (w_wrap) begin
            w_n_active = 1'b0;
            w_n_timer  = '0;
        end else if (r_active) begin
            w_n_timer = r_timer + 1'b1;
        end else if (idle_transmitting) begin
            w_n_level = 1'b1;
            w_n_ones  = 3'd0;
            w_n_timer = '0;
        end
        // Pulse one clock before the last period ends so the control
        // unit's LOAD clock lines up with the final clock of the bit.
        if (w_n_active && (w_n_timer == T_DONE) &&
            (w_n_left == 7'd0) && (w_n_ones != 3'd6))
            w_n_done = 5'd1 << w_n_field;
    end

    // Serializer state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shift  <= '0;
            r_left   <= 7'd0;
            r_field  <= F_SYNC;
            r_active <= 1'b0;
            r_timer  <= '0;
            r_ones   <= 3'd0;
            r_level  <= 1'b1;
            r_done   <= 5'd0;
        end else begin
            r_shift  <= w_n_shift;
            r_left   <= w_n_left;
            r_field  <= w_n_field;
            r_active <= w_n_active;
            r_timer  <= w_n_timer;
            r_ones   <= w_n_ones;
            r_level  <= w_n_level;
            r_done   <= w_n_done;
        end
    end

    assign sync_bits_transmitted  = r_done[0];
    assign pid_bits_transmitted   = r_done[1];
    assign crc5_bits_transmitted  = r_done[2];
    assign crc16_bits_transmitted = r_done[3];
    assign data_bits_transmitted  = r_done[4];

    assign d_plus  = eop_transmitting ? 1'b0 : r_level;
    assign d_minus = eop_transmitting ? 1'b0 : ~r_level;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: packets are expanded into a per-clock
// expected line/pulse trace from bit-level USB rules and compared.
module tb_usb_tx_serializer;

    localparam int C = 8;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [4:0]  ld = 5'd0;
    logic [4:0]  tx = 5'd0;
    logic        idle = 1'b1;
    logic        eop = 1'b0;
    logic [7:0]  t_sync = 8'd0;
    logic [7:0]  t_pid = 8'd0;
    logic [4:0]  t_crc5 = 5'd0;
    logic [15:0] t_crc16 = 16'd0;
    logic [63:0] t_data = 64'd0;
    logic        sync_bt, pid_bt, crc5_bt, crc16_bt, data_bt;
    logic        d_plus, d_minus;
    logic [4:0]  done_v;

    assign done_v = {data_bt, crc16_bt, crc5_bt, pid_bt, sync_bt};

    always #5 clk = ~clk;

    usb_tx_serializer #(.CLKS_PER_BIT(C)) dut (
        .clk                    (clk),
        .n_rst                  (n_rst),
        .sync_load_enable       (ld[0]),
        .pid_load_enable        (ld[1]),
        .crc5_load_enable       (ld[2]),
        .crc16_load_enable      (ld[3]),
        .data_load_enable       (ld[4]),
        .trans_sync             (t_sync),
        .trans_pid              (t_pid),
        .trans_crc5             (t_crc5),
        .trans_crc16            (t_crc16),
        .trans_data             (t_data),
        .idle_transmitting      (idle),
        .sync_transmitting      (tx[0]),
        .pid_transmitting       (tx[1]),
        .crc5_transmitting      (tx[2]),
        .crc16_transmitting     (tx[3]),
        .data_transmitting      (tx[4]),
        .eop_transmitting       (eop),
        .sync_bits_transmitted  (sync_bt),
        .pid_bits_transmitted   (pid_bt),
        .crc5_bits_transmitted  (crc5_bt),
        .crc16_bits_transmitted (crc16_bt),
        .data_bits_transmitted  (data_bt),
        .d_plus                 (d_plus),
        .d_minus                (d_minus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      tag, got, exp, $time);
    endtask

    // Per-clock stimulus and expectation trace for one packet.
    logic [4:0] q_ld[$];
    logic [4:0] q_tx[$];
    logic [4:0] q_done[$];
    bit         q_idle[$];
    bit         q_eop[$];
    bit         q_dp[$];
    bit         q_dm[$];
    int         pkt_f[$];
    int         g_idle;

    function automatic bit fbit(input int f, input int j);
        case (f)
            0:       return t_sync[j];
            1:       return t_pid[j];
            2:       return t_crc5[4-j];
            3:       return t_crc16[15-j];
            default: return t_data[j];
        endcase
    endfunction

    function automatic int flen(input int f);
        case (f)
            0, 1:    return 8;
            2:       return 5;
            3:       return 16;
            default: return 64;
        endcase
    endfunction

    task automatic push_cyc(input logic [4:0] l, input logic [4:0] t,
                            input bit id, input bit e,
                            input bit dp, input bit dm);
        q_ld.push_back(l);
        q_tx.push_back(t);
        q_done.push_back(5'd0);
        q_idle.push_back(id);
        q_eop.push_back(e);
        q_dp.push_back(dp);
        q_dm.push_back(dm);
    endtask

    task automatic push_period(input int f, input bit lv);
        for (int i = 0; i < C; i++)
            push_cyc(5'd0, 5'd1 << f, 1'b0, 1'b0, lv, !lv);
    endtask

    // Expand pkt_f into a trace: idle J, fields back-to-back with
    // stuffing and NRZI, two SE0 clocks, then J again.
    task automatic build();
        bit lv;
        int ones;
        int last;
        logic [4:0] hi;
        logic [4:0] extra;
        q_ld.delete(); q_tx.delete(); q_done.delete();
        q_idle.delete(); q_eop.delete(); q_dp.delete(); q_dm.delete();
        g_idle = $urandom_range(3, 10);
        for (int i = 0; i < g_idle; i++)
            push_cyc(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        lv = 1'b1;
        ones = 0;
        foreach (pkt_f[k]) begin
            last = q_ld.size() - 1;
            hi = 5'b11111 << (pkt_f[k] + 1);
            extra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            q_ld[last] = (5'd1 << pkt_f[k]) | (extra & hi);
            for (int j = 0; j < flen(pkt_f[k]); j++) begin
                if (fbit(pkt_f[k], j)) ones++;
                else begin
                    lv = !lv;
                    ones = 0;
                end
                push_period(pkt_f[k], lv);
                if (ones == 6) begin
                    lv = !lv;
                    ones = 0;
                    push_period(pkt_f[k], lv);
                end
            end
            q_done[q_done.size()-2] = 5'd1 << pkt_f[k];
        end
        last = q_ld.size() - 1;
        q_eop[last] = 1'b1;
        q_dp[last] = 1'b0;
        q_dm[last] = 1'b0;
        push_cyc(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            push_cyc(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic run(input int limit);
        for (int c = 0; c < q_ld.size() && c < limit; c++) begin
            ld = q_ld[c];
            tx = q_tx[c];
            idle = q_idle[c];
            eop = q_eop[c];
            #4;
            check("dplus", 64'(d_plus), 64'(q_dp[c]));
            check("dminus", 64'(d_minus), 64'(q_dm[c]));
            check("done", 64'(done_v), 64'(q_done[c]));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_idle();
        ld = 5'd0;
        tx = 5'd0;
        eop = 1'b0;
        idle = 1'b1;
    endtask

    initial begin
        int kind;
        int dmode;
        repeat (3) @(posedge clk);
        #3;
        check("rst_dplus", 64'(d_plus), 64'd1);
        check("rst_dminus", 64'(d_minus), 64'd0);
        check("rst_done", 64'(done_v), 64'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #4;
            check("idle_dplus", 64'(d_plus), 64'd1);
            check("idle_dminus", 64'(d_minus), 64'd0);
            check("idle_done", 64'(done_v), 64'd0);
            @(posedge clk);
            #1;
        end

        t_sync = 8'h80;
        t_pid = 8'h1E;
        pkt_f = '{0, 1};
        build();
        run(1 << 30);

        t_data = 64'h0000_0000_0000_00FF;
        pkt_f = '{4};
        build();
        run(1 << 30);

        t_crc5 = 5'b10010;
        pkt_f = '{2};
        build();
        run(1 << 30);

        t_data = {$urandom, $urandom};
        pkt_f = '{4};
        build();
        run(g_idle + 20 * C + 3);
        n_rst = 1'b0;
        drive_idle();
        #2;
        check("midrst_dplus", 64'(d_plus), 64'd1);
        check("midrst_dminus", 64'(d_minus), 64'd0);
        check("midrst_done", 64'(done_v), 64'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        for (int i = 0; i < 600; i++) begin
            #4;
            check("postrst_dplus", 64'(d_plus), 64'd1);
            check("postrst_done", 64'(done_v), 64'd0);
            @(posedge clk);
            #1;
        end

        t_sync = 8'h80;
        t_pid = 8'h1E;
        pkt_f = '{0, 1};
        build();
        run(1 << 30);

        for (int p = 0; p < 25; p++) begin
            t_sync = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'($urandom);
            t_pid = 8'($urandom);
            t_crc5 = 5'($urandom);
            t_crc16 = ($urandom_range(0, 3) == 0) ? 16'hFFFF
                                                   : 16'($urandom);
            dmode = $urandom_range(0, 2);
            if (dmode == 0) t_data = {$urandom, $urandom};
            else if (dmode == 1) t_data = '1;
            else t_data = 64'hFF;
            kind = $urandom_range(0, 2);
            if (kind == 0) pkt_f = '{0, 1};
            else if (kind == 1) pkt_f = '{0, 1, 2};
            else pkt_f = '{0, 1, 4, 3};
            build();
            run(1 << 30);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
- Downstream datapath stage of the USB transmit control unit. It consumes that unit's load enables, field values (sync, pid, crc5, crc16, 64-bit data) and per-field transmitting flags.
- It serializes each field at a fixed bit rate, applies USB bit stuffing and NRZI encoding, and drives the differential line (d_plus/d_minus), including J-idle and SE0 end-of-packet.
- It returns a one-clock *_bits_transmitted pulse per field. The control unit uses these pulses to advance its state machine.

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit period; legal range is 2 or more.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous, active-low reset
- sync_load_enable, pid_load_enable, crc5_load_enable, crc16_load_enable, data_load_enable  input  1 each  one-clock field load strobes
- trans_sync  input  8  sync field value
- trans_pid  input  8  PID field value
- trans_crc5  input  5  CRC5 field value
- trans_crc16  input  16  CRC16 field value
- trans_data  input  64  data payload
- idle_transmitting, sync_transmitting, pid_transmitting, crc5_transmitting, crc16_transmitting, data_transmitting, eop_transmitting  input  1 each  control unit phase flags
- sync_bits_transmitted, pid_bits_transmitted, crc5_bits_transmitted, crc16_bits_transmitted, data_bits_transmitted  output  1 each  field-complete pulses
- d_plus  output  1  USB D+ line
- d_minus  output  1  USB D- line

Behaviour:
- Reset (asynchronous, n_rst low):
  - d_plus=1, d_minus=0 (J).
  - All *_bits_transmitted=0.
  - NRZI level=1; ones counter=0; bit timer=0; shifter empty; no active field.
- Field load:
  - On the edge where any *_load_enable is high, capture the field into the shifter and record its length: sync 8, pid 8, crc5 5, crc16 16, data 64.
  - Clear the bit timer; the first bit period starts on the next clock.
  - Bit order: sync, pid and data go out LSB-first; crc5 and crc16 go out MSB-first.
- Bit timing:
  - The timer counts 0..CLKS_PER_BIT-1. Each wrap ends one bit period.
  - Timing runs internally once a field is loaded; it does not depend on *_transmitting staying high.
- NRZI encoding:
  - At each bit-period start, the line level toggles for a 0 bit and holds for a 1 bit.
  - d_plus=level, d_minus=~level.
- Bit stuffing:
  - Count consecutive transmitted 1s across field boundaries.
  - After the 6th consecutive 1, insert one 0 bit period before the next data bit (or before completing the field).
  - The counter clears on any 0 bit (real or stuffed), in idle, and during EOP.
- Done pulse:
  - The matching *_bits_transmitted goes high for exactly one clock at timer index CLKS_PER_BIT-2 of the field's final bit period.
  - If a stuff bit is pending after the final bit, the pulse instead occurs at index CLKS_PER_BIT-2 of the stuff bit's period.
  - This lets the control unit spend its one-clock LOAD state in the final clock (index CLKS_PER_BIT-1), so the next field starts gap-free.
  - At most one done pulse is high in any cycle.
- Idle (idle_transmitting=1, eop_transmitting=0, no field active):
  - Drive J (1,0); set NRZI level to 1; clear the ones counter and timer.
- EOP (eop_transmitting=1):
  - Drive d_plus=d_minus=0 combinationally from the registered phase; this overrides everything else.
  - Abort any remaining bit time; the last bit is truncated by 1 clock, which is accepted.
  - Clear the shifter and ones counter; reset the level to 1 for the following idle.
- Load while a field is active (protocol violation): abort the current field without a done pulse and start the new field at the next edge.
- Simultaneous load enables: priority is sync > pid > crc5 > crc16 > data.
- A done pulse and a load enable in the same clock are legal: the load edge is index CLKS_PER_BIT-1.
- Reset asserted mid-field: immediate return to the reset values above; no pulse is issued.

Test Plan:
- Reset then idle, CLKS_PER_BIT=8 -> d_plus=1, d_minus=0; all done pulses 0 for 100 clocks.
- sync_load_enable with trans_sync=8'h80, then sync_transmitting -> line per bit is K J K J K J K K (d_plus 0,1,0,1,0,1,0,0); sync_bits_transmitted is a single pulse at clock 62 after the first bit starts.
- Sync followed by pid=8'h1E loaded in the LOAD clock -> first PID bit starts at clock 64 with no extra idle clock; NRZI continues from level 0.
- data_load_enable with trans_data=64'h0000_0000_0000_00FF -> stuffed 0 inserted after bit 6 (bit 7 delayed one period); data_bits_transmitted pulse at clock 65*8-2=518.
- trans_crc5=5'b10010, then eop_transmitting after the crc5 done pulse -> bits sent MSB-first 1,0,0,1,0; SE0 (0,0) during both EOP clocks; then J.
- n_rst asserted mid-data field at bit 20 -> next clock d_plus=1, d_minus=0; no data_bits_transmitted pulse; a fresh sync load afterwards behaves exactly as in the sync scenario.
